// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture block: FSM state encoding and
// default parameter values.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_QUIET = 2'd3
    } state_t;

    localparam int DEF_WIDTH      = 12;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_QUIET_CLKS = 4;

    // SCLK divider counter width; covers CLK_DIV up to 255
    localparam int DIV_W = 8;

endpackage

// File: rtl/adc_capture_if.sv
// Request / sample handshake between the ADC capture block and its consumer.
// master: the capture block; slave: the consumer issuing start and ready.
interface adc_capture_if #(
    parameter int WIDTH = adc_pkg::DEF_WIDTH
);
    logic             start;
    logic             busy;
    logic [WIDTH-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready;
    logic             overrun;

    modport master (
        input  start, sample_ready,
        output busy, sample_data, sample_valid, overrun
    );

    modport slave (
        output start, sample_ready,
        input  busy, sample_data, sample_valid, overrun
    );
endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK divider: while enabled, toggles sclk every CLK_DIV system clocks,
// first toggle high-to-low. rise/fall flag the clock in which sclk is about
// to change. Parks sclk high and reloads the divider when disabled.
module adc_sclk_gen import adc_pkg::*; #(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tc;

    assign tc   = en && (div_cnt == '0);
    assign rise = tc && !sclk;
    assign fall = tc && sclk;

    // down-count one half-period, toggle on terminal count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else if (!en) begin
            div_cnt <= DIV_LOAD;
            sclk    <= 1'b1;
        end else if (tc) begin
            div_cnt <= DIV_LOAD;
            sclk    <= !sclk;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/adc_capture.sv
// Serial ADC capture controller: frames a conversion with CS/SCLK, shifts in
// WIDTH data bits after a leading zero, and presents the result on a
// valid/ready handshake with overrun indication.
//
// state | meaning
// IDLE  | CS high, SCLK high, waiting for start
// SETUP | CS low, SCLK high for CLK_DIV clocks
// SHIFT | SCLK runs FRAME_BITS cycles, data sampled on SCLK rises
// QUIET | CS high for QUIET_CLKS clocks before the next frame
module adc_capture import adc_pkg::*; #(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int QUIET_CLKS = DEF_QUIET_CLKS
) (
    input  logic          clk,
    input  logic          reset_n,
    adc_capture_if.master bus,
    output logic          adc_cs,
    output logic          adc_sclk,
    input  logic          adc_sd
);
    localparam int TMR_MAX = (CLK_DIV > QUIET_CLKS) ? CLK_DIV : QUIET_CLKS;
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(WIDTH);
    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] QUIET_LOAD = TMR_W'(QUIET_CLKS - 1);

    state_t           state;
    logic [BIT_W-1:0] bit_cnt;
    logic [TMR_W-1:0] tmr;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] sample_data;
    logic             sample_valid;
    logic             overrun;
    logic             busy;
    logic             cs;
    logic             sclk_en;
    logic             sclk_rise;
    // data is launched by the ADC on SCLK falls, so only rises matter here
    logic             sclk_fall_unused;

    // SCLK stops once the last rise of the frame has been counted
    assign sclk_en = (state == ST_SHIFT) && (bit_cnt != LAST_BIT);

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (sclk_en),
        .sclk    (adc_sclk),
        .rise    (sclk_rise),
        .fall    (sclk_fall_unused)
    );

    assign adc_cs           = cs;
    assign bus.busy         = busy;
    assign bus.sample_data  = sample_data;
    assign bus.sample_valid = sample_valid;
    assign bus.overrun      = overrun;

    // frame sequencing, bit capture and sample handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            tmr          <= '0;
            shift_reg    <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
            cs           <= 1'b1;
        end else begin
            overrun <= 1'b0;
            if (sample_valid && bus.sample_ready) begin
                sample_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state     <= ST_SETUP;
                        busy      <= 1'b1;
                        cs        <= 1'b0;
                        tmr       <= SETUP_LOAD;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                ST_SETUP: begin
                    if (tmr == '0) begin
                        state <= ST_SHIFT;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        // rise 1 is the leading zero, rises past WIDTH+1 are padding
                        if ((bit_cnt != '0) && (bit_cnt <= DATA_LAST)) begin
                            shift_reg <= {shift_reg[WIDTH-2:0], adc_sd};
                        end
                    end else if (bit_cnt == LAST_BIT) begin
                        // a load beats a coinciding accept, so valid stays set
                        state        <= ST_QUIET;
                        cs           <= 1'b1;
                        tmr          <= QUIET_LOAD;
                        sample_data  <= shift_reg;
                        sample_valid <= 1'b1;
                        overrun      <= sample_valid && !bus.sample_ready;
                    end
                end
                ST_QUIET: begin
                    if (tmr == '0) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: behavioural serial ADC, expected-sample
// queue filled when a conversion is requested and drained when the sample
// appears, plus frame-length checks at CLK_DIV = 1, 2 and 3.
module tb_adc_capture;
    import adc_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    adc_capture_if #(.WIDTH(12)) bus  ();
    adc_capture_if #(.WIDTH(12)) bus1 ();
    adc_capture_if #(.WIDTH(12)) bus3 ();

    logic adc_cs, adc_sclk;
    logic adc_sd = 1'b0;
    logic cs1, sclk1, cs3, sclk3;

    adc_capture #(.WIDTH(12), .CLK_DIV(2), .FRAME_BITS(16), .QUIET_CLKS(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .adc_cs(adc_cs), .adc_sclk(adc_sclk), .adc_sd(adc_sd)
    );

    adc_capture #(.WIDTH(12), .CLK_DIV(1), .FRAME_BITS(16), .QUIET_CLKS(4)) dut_div1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .adc_cs(cs1), .adc_sclk(sclk1), .adc_sd(1'b1)
    );

    adc_capture #(.WIDTH(12), .CLK_DIV(3), .FRAME_BITS(16), .QUIET_CLKS(4)) dut_div3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3),
        .adc_cs(cs3), .adc_sclk(sclk3), .adc_sd(1'b1)
    );

    // ADC model: leading zero on the first SCLK fall, then 12 bits MSB-first
    logic [11:0] adc_value = 12'd0;
    logic [11:0] frame_val = 12'd0;
    int          bit_idx   = 0;
    always @(negedge adc_cs or negedge adc_sclk) begin
        if (adc_sclk === 1'b1) begin
            bit_idx   = 0;
            frame_val = adc_value;
            adc_sd    = 1'b0;
        end else if (adc_cs === 1'b0) begin
            bit_idx++;
            if (bit_idx >= 2 && bit_idx <= 13) begin
                adc_sd    = frame_val[11];
                frame_val = frame_val << 1;
            end else begin
                adc_sd = 1'b0;
            end
        end
    end

    int          frames = 0;
    int          ov_cnt = 0;
    logic [11:0] got_q[$];
    logic [11:0] exp_q[$];

    always @(negedge adc_cs) frames++;

    always @(negedge clk) begin
        if (bus.overrun === 1'b1) ov_cnt++;
        if (bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1) got_q.push_back(bus.sample_data);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one conversion on the main DUT; returns busy-high cycle count
    task automatic run_frame(input logic [11:0] value, input int poke, input int ready_at, output int cyc);
        adc_value = value;
        exp_q.push_back(value);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 1000) begin
            cyc++;
            bus.start = (poke != 0 && (cyc == poke || cyc == 70 || cyc == 71));
            if (ready_at != 0) bus.sample_ready = (cyc == ready_at);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (ready_at != 0) bus.sample_ready = 1'b0;
    endtask

    function automatic logic [11:0] pop_exp();
        if (exp_q.size() == 0) return 12'hxxx;
        return exp_q.pop_front();
    endfunction

    initial begin
        logic [11:0] e;
        logic [11:0] g;
        int          cyc;
        int          f0;
        int          o0;

        bus.start  = 1'b0; bus.sample_ready  = 1'b0;
        bus1.start = 1'b0; bus1.sample_ready = 1'b0;
        bus3.start = 1'b0; bus3.sample_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cs",      adc_cs,           1);
        check("rst_sclk",    adc_sclk,         1);
        check("rst_valid",   bus.sample_valid, 0);
        check("rst_data",    bus.sample_data,  0);
        check("rst_busy",    bus.busy,         0);
        check("rst_overrun", bus.overrun,      0);

        // start together with reset release
        reset_n = 1'b1;
        o0 = ov_cnt;
        run_frame(12'd200, 0, 0, cyc);
        e = pop_exp();
        check("f1_len",      cyc,              71);
        check("f1_valid",    bus.sample_valid, 1);
        check("f1_data",     bus.sample_data,  e);
        check("f1_no_ovr",   ov_cnt - o0,      0);
        bus.sample_ready = 1'b1;
        @(negedge clk);
        bus.sample_ready = 1'b0;
        check("f1_accept_clears", bus.sample_valid, 0);

        // back-to-back frames with the consumer always ready
        got_q.delete();
        o0 = ov_cnt;
        bus.sample_ready = 1'b1;
        run_frame(12'd200, 0, 0, cyc);
        run_frame(12'd200, 0, 0, cyc);
        run_frame(12'd0,   0, 0, cyc);
        run_frame(12'd0,   0, 0, cyc);
        bus.sample_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = pop_exp();
            g = (got_q.size() != 0) ? got_q.pop_front() : 12'hxxx;
            check($sformatf("b2b_%0d", i), g, e);
        end
        check("b2b_no_ovr", ov_cnt - o0, 0);
        check("b2b_idle_valid", bus.sample_valid, 0);

        // two loads without an accept
        o0 = ov_cnt;
        run_frame(12'hA5A, 0, 0, cyc);
        e = pop_exp();
        check("ovr_first_data", bus.sample_data, e);
        check("ovr_first_none", ov_cnt - o0,     0);
        run_frame(12'h3C3, 0, 0, cyc);
        e = pop_exp();
        check("ovr_second_data",  bus.sample_data,  e);
        check("ovr_pulse_cycles", ov_cnt - o0,      1);
        check("ovr_valid",        bus.sample_valid, 1);

        // accept lands in the same clock as the next load (clock 67 of the frame)
        o0 = ov_cnt;
        run_frame(12'h7FF, 0, 67, cyc);
        e = pop_exp();
        check("coin_valid",  bus.sample_valid, 1);
        check("coin_data",   bus.sample_data,  e);
        check("coin_no_ovr", ov_cnt - o0,      0);
        bus.sample_ready = 1'b1;
        @(negedge clk);
        bus.sample_ready = 1'b0;
        check("coin_accept_clears", bus.sample_valid, 0);

        // start pulses while busy (SETUP and the last two QUIET clocks) are dropped
        f0 = frames;
        run_frame(12'h123, 5, 0, cyc);
        e = pop_exp();
        check("drop_frames", frames - f0,     1);
        check("drop_len",    cyc,             71);
        check("drop_data",   bus.sample_data, e);
        repeat (3) @(negedge clk);
        check("drop_stays_idle", bus.busy, 0);

        // reset during SHIFT after the 6th SCLK rise, with SCLK low
        adc_value = 12'h555;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (28) @(negedge clk);
        check("mid_in_frame", adc_cs, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_cs",    adc_cs,           1);
        check("mid_rst_sclk",  adc_sclk,         1);
        check("mid_rst_valid", bus.sample_valid, 0);
        check("mid_rst_busy",  bus.busy,         0);
        check("mid_rst_data",  bus.sample_data,  0);
        @(negedge clk);
        reset_n = 1'b1;
        run_frame(12'h9C4, 0, 0, cyc);
        e = pop_exp();
        check("post_rst_len",   cyc,              71);
        check("post_rst_valid", bus.sample_valid, 1);
        check("post_rst_data",  bus.sample_data,  e);

        // frame length at CLK_DIV=1 and CLK_DIV=3, data line held high
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        cyc = 0;
        while (bus1.busy === 1'b1 && cyc < 1000) begin
            cyc++;
            @(negedge clk);
        end
        check("div1_len",  cyc,              38);
        check("div1_data", bus1.sample_data, 12'hFFF);

        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        cyc = 0;
        while (bus3.busy === 1'b1 && cyc < 1000) begin
            cyc++;
            @(negedge clk);
        end
        check("div3_len",  cyc,              104);
        check("div3_data", bus3.sample_data, 12'hFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter WIDTH, 12, sample width in bits.
REQ-002 Parameter CLK_DIV, 2, system clocks per SCLK half-period; legal values 1..255.
REQ-003 Parameter FRAME_BITS, 16, SCLK cycles per conversion frame; must be at least WIDTH+2.
REQ-004 Parameter QUIET_CLKS, 4, minimum system clocks with CS high between frames; must be at least 1.
REQ-005 Port clk, input, 1, system clock; all logic on the rising edge.
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, single-cycle conversion request.
REQ-008 Port adc_cs, output, 1, ADC chip select; high = idle/reset, low = converting.
REQ-009 Port adc_sclk, output, 1, ADC serial clock; idles high.
REQ-010 Port adc_sd, input, 1, ADC serial data, driven by the ADC on SCLK falling edges.
REQ-011 Port sample_data, output, WIDTH, last captured sample, unsigned.
REQ-012 Port sample_valid, output, 1, sample_data holds an unconsumed sample.
REQ-013 Port sample_ready, input, 1, consumer accepts the sample.
REQ-014 Port busy, output, 1, high in any state other than IDLE.
REQ-015 Port overrun, output, 1, one-cycle pulse when a new sample replaces an unconsumed one.

Function
REQ-016 The FSM SHALL have four states: IDLE, SETUP, SHIFT and QUIET.
REQ-017 IDLE: adc_cs=1 and adc_sclk=1; when start=1, go to SETUP on the next clock.
REQ-018 In IDLE, a start pulse SHALL be ignored unless it arrives in IDLE; start during busy is dropped without being queued.
REQ-019 SETUP: adc_cs=0 and adc_sclk=1 for CLK_DIV clocks, then go to SHIFT.
REQ-020 SHIFT: adc_sclk SHALL toggle every CLK_DIV clocks.
REQ-021 SHIFT: the first toggle is high-to-low, producing exactly FRAME_BITS full low/high SCLK cycles.
REQ-022 SHIFT: the state ends with adc_sclk high.
REQ-023 adc_sd SHALL be sampled in the system clock where adc_sclk goes low-to-high (rising SCLK edges 1..FRAME_BITS).
REQ-024 Rising edge 1 carries the leading zero and SHALL be discarded.
REQ-025 Rising edges 2..WIDTH+1 carry data MSB-first and SHALL shift into the capture register.
REQ-026 Rising edges beyond WIDTH+1 SHALL be ignored.
REQ-027 After the final rising edge, assert adc_cs=1 in the next clock and enter QUIET.
REQ-028 QUIET: hold adc_cs=1 and adc_sclk=1 for QUIET_CLKS clocks, then return to IDLE.
REQ-029 On entry to QUIET, load the capture register into sample_data and set sample_valid=1.
REQ-030 On entry to QUIET, if sample_valid was already 1 and sample_ready=0 in that cycle, pulse overrun for one clock (the new sample overwrites).
REQ-031 sample_valid SHALL clear in the cycle after sample_valid&&sample_ready.
REQ-032 If a load and an accept coincide, the load wins and sample_valid stays 1 with no overrun.
REQ-033 sample_data SHALL be stable while sample_valid=1 except on a load.
REQ-034 The bit counter SHALL be sized clog2(FRAME_BITS+1) and the divider counter 8 bits; neither wraps within a frame.
REQ-035 Frame length in clocks SHALL be CLK_DIV*(1+2*FRAME_BITS)+1+QUIET_CLKS from the start cycle to the return to IDLE.

Reset
REQ-036 With reset_n=0, the block SHALL immediately (asynchronously) enter IDLE with adc_cs=1, adc_sclk=1, sample_data=0, sample_valid=0, overrun=0, busy=0, and all counters at 0.
REQ-037 Reset mid-frame SHALL abort the frame, and no partial sample is ever presented.
REQ-038 The first start after reset_n deasserts SHALL be honoured from the next clock.

Structure
REQ-039 Package adc_pkg SHALL hold the state encoding (2-bit enum) and the default WIDTH/FRAME_BITS constants.
REQ-040 One sub-module, adc_sclk_gen (divider producing sclk level, rise and fall strobes, enabled by the FSM), SHALL be instantiated; everything else is inline.

Verification
REQ-041 Bench connects adc_model (WIDTH=12, PERIOD large) and drives start once: sample_data=12'd200 (0x0C8), sample_valid=1, overrun=0.
REQ-042 Four back-to-back starts across a model level change SHALL yield the sequence 200,200,0,0 (or per the model toggle point), each accepted with sample_ready=1.
REQ-043 Two frames with sample_ready held 0 SHALL produce a one-cycle overrun pulse on the second load, with sample_data equal to the second value.
REQ-044 Start asserted while busy SHALL be dropped: the frame count stays 1, and a cycle-count check against REQ-035 passes for CLK_DIV=1 and CLK_DIV=3.
REQ-045 reset_n pulsed low in SHIFT at bit 6 SHALL force adc_cs=1, sample_valid=0 and IDLE, and the next start SHALL capture the correct full value.
REQ-046 Accept and load in the same cycle SHALL leave sample_valid=1 with the new data and overrun=0.
